// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses imem, registers the word into the IF/ID stage.
// Latency: the word at pc appears on if_instr one cycle later; one instruction per cycle when id_ready=1.
// Backpressure: if_valid & ~id_ready freezes pc and the IF/ID register; a redirect squashes even a stalled word.
module fetch_unit #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [31:0]       HALT_INSTR = 32'h00000073
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              stall;
  logic              fire;
  logic              capture;
  logic              is_halt;

  assign stall     = if_valid & ~id_ready;
  assign fire      = if_valid & id_ready;
  assign capture   = (state == RUN) & ~redirect_valid & ~stall;
  assign is_halt   = (imem_instr == HALT_INSTR);
  assign imem_addr = pc;
  assign halted    = (state == HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A halt capture wins over enable dropping: the PC is parked on the halt word either way.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN: begin
        if (capture && is_halt) state_nxt = HALTED;
        else if (!enable)       state_nxt = IDLE;
      end
      HALTED:  if (redirect_valid) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      fetch_count <= '0;
    end else begin
      if (fire && fetch_count != 16'hFFFF) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (redirect_valid) begin
        pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
        if_valid <= 1'b0;
      end else if (!stall) begin
        if (state == RUN) begin
          if_instr <= imem_instr;
          if_pc    <= pc;
          if_valid <= 1'b1;
          // The halt word is delivered but the PC stays parked on it.
          if (!is_halt) begin
            pc <= pc + ADDR_W'(4);
          end
        end else if (fire) begin
          if_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'h00000073;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [64];

  int n_vec = 0;
  int n_err = 0;

  typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
  mode_t       m_mode;
  bit [7:0]    m_pc;
  bit [7:0]    m_ipc;
  bit [31:0]   m_instr;
  bit          m_valid;
  int unsigned m_count;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  assign imem_instr = mem[imem_addr[7:2]];

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: one clock of the fetch stage, straight from the behavioural rules.
  task automatic model_step();
    bit        fire;
    bit        stall;
    bit        fetched;
    bit [31:0] word;
    word = mem[m_pc[7:2]];
    if (reset) begin
      m_mode = M_IDLE; m_pc = 8'h00; m_ipc = 8'h00; m_instr = 0; m_valid = 0; m_count = 0;
    end else begin
      fire    = m_valid && id_ready;
      stall   = m_valid && !id_ready;
      fetched = (m_mode == M_RUN) && !redirect_valid && !stall;
      if (fire && m_count < 65535) m_count++;
      if (redirect_valid) begin
        m_pc    = redirect_pc & 8'hFC;
        m_valid = 0;
      end else if (!stall) begin
        if (m_mode == M_RUN) begin
          m_instr = word;
          m_ipc   = m_pc;
          m_valid = 1;
          if (word != HALT) m_pc = 8'((int'(m_pc) + 4) % 256);
        end else if (fire) begin
          m_valid = 0;
        end
      end
      case (m_mode)
        M_IDLE: if (enable) m_mode = M_RUN;
        M_RUN: begin
          if (fetched && word == HALT) m_mode = M_HALT;
          else if (!enable)            m_mode = M_IDLE;
        end
        M_HALT: if (redirect_valid) m_mode = M_RUN;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_val("imem_addr",   {24'h0, imem_addr},   {24'h0, m_pc});
    check_val("if_valid",    {31'h0, if_valid},    {31'h0, m_valid});
    check_val("if_instr",    if_instr,             m_instr);
    check_val("if_pc",       {24'h0, if_pc},       {24'h0, m_ipc});
    check_val("halted",      {31'h0, halted},      {31'h0, (m_mode == M_HALT)});
    check_val("fetch_count", {16'h0, fetch_count}, m_count);
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      do w = $urandom; while (w == HALT);
      mem[i] = w;
    end
    mem[0]  = 32'h00007033;
    mem[1]  = 32'h00100093;
    mem[2]  = 32'h00200113;
    mem[3]  = 32'h00308193;
    mem[8]  = 32'h00208433;
    mem[18] = HALT;

    reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; id_ready = 1'b0;
    cycle();
    cycle();
    check_val("rst_valid", {31'h0, if_valid}, 32'h0);
    check_val("rst_addr",  {24'h0, imem_addr}, 32'h0);
    check_val("rst_count", {16'h0, fetch_count}, 32'h0);

    // Straight-line fetch
    reset = 1'b0; enable = 1'b1; id_ready = 1'b1;
    cycle();
    cycle();
    check_val("t1_pc0",    {24'h0, if_pc}, 32'h00);
    check_val("t1_instr0", if_instr, 32'h00007033);
    cycle();
    check_val("t1_pc1",    {24'h0, if_pc}, 32'h04);
    check_val("t1_instr1", if_instr, 32'h00100093);
    cycle();
    check_val("t1_pc2",    {24'h0, if_pc}, 32'h08);
    check_val("t1_instr2", if_instr, 32'h00200113);

    // Decode back-pressure
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("t2_hold_instr", if_instr, 32'h00200113);
      check_val("t2_hold_addr",  {24'h0, imem_addr}, 32'h0C);
    end
    id_ready = 1'b1;
    cycle();
    check_val("t2_next_instr", if_instr, 32'h00308193);
    check_val("t2_count",      {16'h0, fetch_count}, 32'd3);

    // Redirect during a stall squashes the held word
    id_ready = 1'b0;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 8'h23;
    cycle();
    check_val("t3_bubble", {31'h0, if_valid}, 32'h0);
    check_val("t3_addr",   {24'h0, imem_addr}, 32'h20);
    redirect_valid = 1'b0; id_ready = 1'b1;
    cycle();
    check_val("t3_instr", if_instr, 32'h00208433);
    check_val("t3_pc",    {24'h0, if_pc}, 32'h20);

    // Wrap-around at the top of memory
    redirect_valid = 1'b1; redirect_pc = 8'hFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check_val("t4_pc_top", {24'h0, if_pc}, 32'hFC);
    check_val("t4_wrap",   {24'h0, imem_addr}, 32'h00);
    cycle();
    check_val("t4_pc0",    {24'h0, if_pc}, 32'h00);
    check_val("t4_instr0", if_instr, 32'h00007033);

    // Halt instruction at 0x48
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    cycle();
    cycle();
    check_val("t5_instr",  if_instr, HALT);
    check_val("t5_halted", {31'h0, halted}, 32'h1);
    check_val("t5_addr",   {24'h0, imem_addr}, 32'h48);
    cycle();
    check_val("t5_drop",   {31'h0, if_valid}, 32'h0);
    check_val("t5_park",   {24'h0, imem_addr}, 32'h48);
    cycle();
    check_val("t5_still",  {31'h0, halted}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    cycle();
    redirect_valid = 1'b0;
    check_val("t5_resume", {31'h0, halted}, 32'h0);
    cycle();
    check_val("t5_refetch", if_instr, 32'h00007033);

    // Reset in the middle of a stalled stream
    cycle();
    id_ready = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    check_val("t6_valid", {31'h0, if_valid}, 32'h0);
    check_val("t6_pc",    {24'h0, imem_addr}, 32'h00);
    check_val("t6_count", {16'h0, fetch_count}, 32'h0);
    reset = 1'b0; enable = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("t6_idle", {31'h0, if_valid}, 32'h0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 255) == 0);
      enable         = ($urandom_range(0, 99) < 85);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 8'($urandom);
      id_ready       = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
